// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter, 10-bit binary to four BCD digits, one step per clock,
// with optional blanking of leading zero digits (4'hF) for a 7-segment decoder.
module bin_to_bcd #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] bin,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       done
);
  localparam logic IDLE = 1'b0;
  localparam logic CONV = 1'b1;
  localparam logic [3:0] HI_RST = BLANK_LEADING ? 4'hF : 4'h0;
  logic        state;
  logic [9:0]  sh;
  logic [15:0] scr, adj, nxt;
  logic [3:0]  cnt;
  logic        z3, z2, z1;
  assign in_ready = state == IDLE;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign adj[4*g+:4] = scr[4*g+:4] >= 4'd5 ? scr[4*g+:4] + 4'd3 : scr[4*g+:4];
  end
  assign nxt = {adj[14:0], sh[9]};
  // blanking chains from the most significant digit down; bcd0 is never blanked
  assign z3 = BLANK_LEADING && nxt[15:12] == 4'd0;
  assign z2 = z3 && nxt[11:8] == 4'd0;
  assign z1 = z2 && nxt[7:4] == 4'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      scr   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      bcd0  <= 4'h0;
      bcd1  <= HI_RST;
      bcd2  <= HI_RST;
      bcd3  <= HI_RST;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          sh    <= bin;
          scr   <= '0;
          cnt   <= '0;
          state <= CONV;
        end
      end else begin
        sh  <= {sh[8:0], 1'b0};
        scr <= nxt;
        cnt <= cnt + 4'd1;
        if (cnt == 4'd9) begin
          state <= IDLE;
          done  <= 1'b1;
          bcd0  <= nxt[3:0];
          bcd1  <= z1 ? 4'hF : nxt[7:4];
          bcd2  <= z2 ? 4'hF : nxt[11:8];
          bcd3  <= z3 ? 4'hF : nxt[15:12];
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: drives a blanking and a non-blanking instance in lockstep; expected digits are queued
// at acceptance and compared whenever either instance pulses done.
module tb_bin_to_bcd;
  logic       clk = 1'b0;
  logic       reset, in_valid;
  logic [9:0] bin;
  logic       rdy0, rdy1, done0, done1;
  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [15:0] q0[$], q1[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bin_to_bcd u0 (.clk(clk), .reset(reset), .bin(bin), .in_valid(in_valid), .in_ready(rdy0),
                 .bcd0(a0), .bcd1(a1), .bcd2(a2), .bcd3(a3), .done(done0));
  bin_to_bcd #(.BLANK_LEADING(1'b0)) u1 (.clk(clk), .reset(reset), .bin(bin), .in_valid(in_valid),
                 .in_ready(rdy1), .bcd0(b0), .bcd1(b1), .bcd2(b2), .bcd3(b3), .done(done1));
  function automatic logic [15:0] model(int v, bit blank);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'(v / 1000);
    if (blank && d3 == 4'd0) begin
      d3 = 4'hF;
      if (d2 == 4'd0) begin
        d2 = 4'hF;
        if (d1 == 4'd0) d1 = 4'hF;
      end
    end
    return {d3, d2, d1, d0};
  endfunction
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input int v);
    q0.push_back(model(v, 1'b1));
    q1.push_back(model(v, 1'b0));
  endtask
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) check("done0_unexpected", 16'd1, 16'd0);
      else check("digits_blank", {a3, a2, a1, a0}, q0.pop_front());
    end
    if (done1) begin
      if (q1.size() == 0) check("done1_unexpected", 16'd1, 16'd0);
      else check("digits_plain", {b3, b2, b1, b0}, q1.pop_front());
    end
  end
  task automatic wait_done_exact();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_ready_done", {14'd0, rdy0, done0}, 16'd0);
    end
    @(negedge clk);
    check("done_cycle", {12'd0, rdy0, done0, rdy1, done1}, 16'hF);
  endtask
  task automatic convert(input int v);
    bin = 10'(v);
    in_valid = 1'b1;
    push(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done_exact();
    @(negedge clk);
    check("done_low_after", {15'd0, done0}, 16'd0);
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    bin = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_blank", {a3, a2, a1, a0}, 16'hFFF0);
    check("reset_plain", {b3, b2, b1, b0}, 16'h0000);
    check("reset_ready_done", {14'd0, rdy0, done0}, 16'd2);
    repeat (3) @(negedge clk);
    check("idle_hold", {a3, a2, a1, a0, 3'd0, done0}, {16'hFFF0, 4'd0});
    convert(0);
    convert(1023);
    convert(1000);
    convert(42);
    convert(9);
    convert(100);
    // 507 then 42 with in_valid held high through the conversion
    @(posedge clk);
    #1 bin = 10'd507;
    in_valid = 1'b1;
    push(507);
    @(posedge clk);
    #1 bin = 10'd42;
    push(42);
    wait_done_exact();
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done_exact();
    // abort a 999 conversion with reset on edge A+5
    @(posedge clk);
    #1 bin = 10'd999;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {15'd0, rdy0}, 16'd1);
    check("abort_outputs", {a3, a2, a1, a0}, 16'hFFF0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", {14'd0, done0, done1}, 16'd0);
    end
    convert(7);
    // full sweep on both instances
    for (int v = 0; v < 1024; v++) begin
      int n;
      n = 0;
      while (!rdy0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("sweep_ready_timeout", 16'd1, 16'd0);
      @(posedge clk);
      #1 bin = 10'(v);
      in_valid = 1'b1;
      push(v);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!done0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("sweep_done_timeout", 16'd1, 16'd0);
    end
    repeat (3) @(negedge clk);
    check("queues_drained", 16'(q0.size() + q1.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
